imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port instruction memory (2^DEPTH_LOG2 words, word-indexed by byte address [DEPTH_LOG2+1:2], 1-cycle registered read) between two requesters: the IF-stage fetch port and the program loader/debug port.
- After reset it holds the CPU off while the loader writes the program (BOOT). It then gives fetch priority, with a starvation guard that guarantees the loader access.
- Sits between the IF stage, the loader, and the memory array.

Parameters:
- DATA_W, 32, instruction/data word width
- DEPTH_LOG2, 10, log2 of memory depth in words
- MAX_WAIT, 8, consecutive denied loader cycles before a forced loader grant (≥1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch read request
- if_addr  input  32  fetch byte address
- if_gnt  output  1  fetch access issued this cycle
- if_valid  output  1  if_inst valid (one cycle after if_gnt)
- if_inst  output  DATA_W  fetched instruction
- ld_req  input  1  loader request
- ld_we  input  1  loader write (1) / read (0)
- ld_addr  input  32  loader byte address
- ld_wdata  input  DATA_W  loader write data
- ld_done  input  1  pulse: program load finished, leave BOOT
- ld_gnt  output  1  loader access issued this cycle
- ld_valid  output  1  ld_rdata valid (one cycle after a loader read grant)
- ld_rdata  output  DATA_W  loader read data
- boot_busy  output  1  high while in BOOT; the CPU stays stalled
- mem_en  output  1  memory access enable
- mem_we  output  1  memory write enable
- mem_addr  output  DEPTH_LOG2  word index
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- States: BOOT, RUN, FORCE. Reset → BOOT.
- Reset values: state=BOOT, wait counter=0, owner=none. All grant and valid outputs are 0, mem_en=0, mem_we=0. Data outputs are 0. boot_busy=1.
- Grants are combinational from the current state and requests. Exactly one of if_gnt/ld_gnt is high, or neither. mem_en = if_gnt | ld_gnt. mem_we = ld_gnt & ld_we.
- Address: mem_addr = granted addr[DEPTH_LOG2+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so out-of-range addresses wrap.
- BOOT:
  - if_gnt=0 always.
  - ld_gnt = ld_req.
  - ld_done → RUN on the next edge. If ld_done and ld_req coincide, the access is still granted this cycle.
- RUN:
  - if_req=1 → if_gnt=1 and the loader is denied.
  - Otherwise ld_gnt = ld_req.
  - Wait counter increments each cycle with ld_req & !ld_gnt, saturating at MAX_WAIT. It clears on ld_gnt or when ld_req=0.
  - When the counter reaches MAX_WAIT → FORCE on the next edge.
- FORCE (exactly one cycle):
  - ld_gnt = ld_req, and if_gnt=0 even if if_req=1. If ld_req dropped meanwhile, no access occurs.
  - Counter clears. Next state is RUN.
- ld_done outside BOOT is ignored.
- Read return:
  - A registered owner tag records which port was granted for a read.
  - Next cycle, the owner's valid pulses for one cycle and its data output loads mem_rdata.
  - Data outputs hold their last value until the next valid.
  - Writes produce no valid.
- A fetch read and a loader write to the same word cannot occur in the same cycle (single port).
- If the loader writes then fetch reads the same word on the next cycle, fetch gets the new data.
- The requester must hold req/addr stable until it sees gnt. The arbiter never queues requests.
- rst mid-operation: the pending valid is dropped, the state returns to BOOT, and the counter is cleared.

Test Plan:
- Reset, then loader writes 0x20010028 @0x0 and 0x20050000 @0x4, then ld_done. Expected: boot_busy=1 and if_gnt=0 throughout; boot_busy falls the cycle after ld_done; memory holds both words.
- In RUN, fetch reads 0x4. Expected: if_gnt same cycle; one cycle later if_valid=1 and if_inst=0x20050000; ld_valid stays 0.
- if_req held high with ld_req high (read 0x0), MAX_WAIT=8. Expected: loader denied 8 cycles; FORCE on cycle 9 gives ld_gnt=1 and if_gnt=0; ld_valid with 0x20010028 on the next cycle; fetch regranted after FORCE.
- In BOOT, if_req=1 with no ld_req. Expected: no grants, mem_en=0.
- Loader writes 0xDEADBEEF @0x1000 (DEPTH_LOG2=10). Expected: wraps to word 0; a later fetch @0x0 returns 0xDEADBEEF.
- Assert rst the cycle after a fetch grant. Expected: if_valid stays 0; state BOOT; boot_busy=1.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction memory between the IF-stage
// fetch port and the program loader/debug port. After reset the loader owns
// the memory (BOOT) until it signals ld_done; afterwards fetch has priority
// and a wait counter forces a one-cycle loader grant (FORCE) so the loader
// cannot starve.
module imem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_inst,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [31:0]           ld_addr,
    input  logic [DATA_W-1:0]     ld_wdata,
    input  logic                  ld_done,
    output logic                  ld_gnt,
    output logic                  ld_valid,
    output logic [DATA_W-1:0]     ld_rdata,
    output logic                  boot_busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FORCE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    state_t              state;
    owner_t              owner_p1;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   if_inst_q;
    logic [DATA_W-1:0]   ld_rdata_q;
    logic                ld_denied;

    // Grant decode from the current state and the live requests
    always_comb begin
        if_gnt = 1'b0;
        ld_gnt = 1'b0;
        case (state)
            BOOT: begin
                ld_gnt = ld_req;
            end
            RUN: begin
                if_gnt = if_req;
                ld_gnt = ld_req & ~if_req;
            end
            FORCE: begin
                ld_gnt = ld_req;
            end
            default: begin
                if_gnt = 1'b0;
                ld_gnt = 1'b0;
            end
        endcase
    end

    assign ld_denied = ld_req & ~ld_gnt;
    assign boot_busy = (state == BOOT);

    // Memory port: word index taken from the granted byte address; upper
    // address bits are dropped so out-of-range addresses wrap.
    assign mem_en    = if_gnt | ld_gnt;
    assign mem_we    = ld_gnt & ld_we;
    assign mem_addr  = if_gnt ? if_addr[DEPTH_LOG2+1:2] :
                       ld_gnt ? ld_addr[DEPTH_LOG2+1:2] : '0;
    assign mem_wdata = ld_gnt ? ld_wdata : '0;

    // State machine and loader starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            wait_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    wait_cnt <= '0;
                    if (ld_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (ld_denied) begin
                        // The denial that brings the count to MAX_WAIT hands
                        // the very next cycle to the loader.
                        if (wait_cnt >= CNT_LAST) begin
                            wait_cnt <= CNT_MAX;
                            state    <= FORCE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                FORCE: begin
                    wait_cnt <= '0;
                    state    <= RUN;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= BOOT;
                end
            endcase
        end
    end

    // Owner tag for the read issued this cycle; writes leave no owner
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_p1 <= OWN_NONE;
        end else if (if_gnt) begin
            owner_p1 <= OWN_IF;
        end else if (ld_gnt & ~ld_we) begin
            owner_p1 <= OWN_LD;
        end else begin
            owner_p1 <= OWN_NONE;
        end
    end

    // A reset landing on the return cycle drops the pending valid
    assign if_valid = (owner_p1 == OWN_IF) & ~rst;
    assign ld_valid = (owner_p1 == OWN_LD) & ~rst;

    // Read data is forwarded straight from memory on the valid cycle and
    // held afterwards until the next valid for the same port.
    assign if_inst  = if_valid ? mem_rdata : if_inst_q;
    assign ld_rdata = ld_valid ? mem_rdata : ld_rdata_q;

    // Hold registers for the returned read data
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst_q  <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (if_valid) begin
                if_inst_q <= mem_rdata;
            end
            if (ld_valid) begin
                ld_rdata_q <= mem_rdata;
            end
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:DEPTH_LOG2+2], if_addr[1:0],
                                ld_addr[31:DEPTH_LOG2+2], ld_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed-vector bench for imem_arbiter with a behavioural
// single-port memory. Stimulus pushes expected read returns into per-port
// queues; a monitor pops and compares whenever a valid appears.
module tb_imem_arbiter;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int MAX_WAIT   = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_gnt;
    logic                  if_valid;
    logic [DATA_W-1:0]     if_inst;
    logic                  ld_req;
    logic                  ld_we;
    logic [31:0]           ld_addr;
    logic [DATA_W-1:0]     ld_wdata;
    logic                  ld_done;
    logic                  ld_gnt;
    logic                  ld_valid;
    logic [DATA_W-1:0]     ld_rdata;
    logic                  boot_busy;
    logic                  mem_en;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    imem_arbiter #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .ld_req   (ld_req),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_done  (ld_done),
        .ld_gnt   (ld_gnt),
        .ld_valid (ld_valid),
        .ld_rdata (ld_rdata),
        .boot_busy(boot_busy),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory, 1-cycle registered read
    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t if_q[$];
    exp_t ld_q[$];

    int checks = 0;
    int errors = 0;
    logic stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa,
                         input logic ldr, input logic we, input logic [31:0] lda,
                         input logic [31:0] wd, input logic done);
        @(posedge clk);
        #1;
        if_req   = ifr;
        if_addr  = ifa;
        ld_req   = ldr;
        ld_we    = we;
        ld_addr  = lda;
        ld_wdata = wd;
        ld_done  = done;
        #1;
    endtask

    task automatic push_if(input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        if_q.push_back(e);
    endtask

    task automatic push_ld(input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        ld_q.push_back(e);
    endtask

    // Monitor: compare every presented read return against the queues
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                if (if_q.size() == 0) begin
                    chk("if_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_inst", if_inst, e.data);
                    chk("if_valid_cycle", cyc, e.cyc);
                end
            end
            if (ld_valid === 1'b1) begin
                if (ld_q.size() == 0) begin
                    chk("ld_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = ld_q.pop_front();
                    chk("ld_rdata", ld_rdata, e.data);
                    chk("ld_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_boot_busy", boot_busy, 1);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_ld_gnt", ld_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_ld_rdata", ld_rdata, 0);

        // BOOT: fetch requests are held off
        drive(1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        rst = 1'b0;
        drive(1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("boot_if_gnt", if_gnt, 0);
        chk("boot_ld_gnt", ld_gnt, 0);
        chk("boot_mem_en", mem_en, 0);
        chk("boot_busy_idle", boot_busy, 1);

        // BOOT: program load, fetch still requesting
        drive(1, 32'h0, 1, 1, 32'h0, 32'h20010028, 0);
        chk("boot_wr0_ld_gnt", ld_gnt, 1);
        chk("boot_wr0_if_gnt", if_gnt, 0);
        chk("boot_wr0_mem_we", mem_we, 1);
        chk("boot_wr0_mem_addr", 32'(mem_addr), 0);
        chk("boot_wr0_mem_wdata", mem_wdata, 32'h20010028);
        drive(1, 32'h0, 1, 1, 32'h4, 32'h20050000, 1);
        chk("boot_wr1_ld_gnt", ld_gnt, 1);
        chk("boot_wr1_if_gnt", if_gnt, 0);
        chk("boot_wr1_mem_addr", 32'(mem_addr), 1);
        chk("boot_wr1_busy", boot_busy, 1);

        // RUN: boot_busy falls after ld_done
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("run_boot_busy", boot_busy, 0);
        chk("mem_word0", mem[0], 32'h20010028);
        chk("mem_word1", mem[1], 32'h20050000);

        // RUN: fetch read @0x4
        drive(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
        chk("fetch4_if_gnt", if_gnt, 1);
        chk("fetch4_mem_we", mem_we, 0);
        chk("fetch4_mem_addr", 32'(mem_addr), 1);
        push_if(32'h20050000);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("fetch4_hold", if_inst, 32'h20050000);

        // RUN: fetch hogs the port, loader read @0x0 waits for FORCE
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(1, 32'h0, 1, 0, 32'h0, 32'h0, 0);
            chk("starve_if_gnt", if_gnt, 1);
            chk("starve_ld_gnt", ld_gnt, 0);
            push_if(32'h20010028);
        end
        drive(1, 32'h0, 1, 0, 32'h0, 32'h0, 0);
        chk("force_ld_gnt", ld_gnt, 1);
        chk("force_if_gnt", if_gnt, 0);
        push_ld(32'h20010028);
        drive(1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("after_force_if_gnt", if_gnt, 1);
        push_if(32'h20010028);

        // RUN: ld_done ignored; wrapped write @0x1000 then fetch @0x0
        drive(0, 32'h0, 1, 1, 32'h1000, 32'hDEADBEEF, 1);
        chk("wrap_ld_gnt", ld_gnt, 1);
        chk("wrap_mem_addr", 32'(mem_addr), 0);
        drive(1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("wrap_if_gnt", if_gnt, 1);
        chk("ld_done_ignored", boot_busy, 0);
        push_if(32'hDEADBEEF);
        drive(0, 32'h0, 1, 0, 32'h1000, 32'h0, 0);
        chk("ldrd_ld_gnt", ld_gnt, 1);
        push_ld(32'hDEADBEEF);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

        // Reset the cycle after a fetch grant: the return is dropped
        drive(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
        chk("prerst_if_gnt", if_gnt, 1);
        drive(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_if_valid", if_valid, 0);
        drive(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_boot_busy", boot_busy, 1);
        chk("rst_mid_if_gnt", if_gnt, 0);
        chk("rst_mid_if_valid2", if_valid, 0);
        drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        chk("rst_mid_boot_busy2", boot_busy, 1);

        repeat (3) @(posedge clk);
        #2;
        chk("if_q_drained", if_q.size(), 0);
        chk("ld_q_drained", ld_q.size(), 0);
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
